// File: rtl/flash_boot_if.sv
// Bus bundle between the boot copier and its SPI byte engine, SRAM write port and GO strobe.
// The master side is the copier; the slave side is the SPI engine, SRAM and CPU glue.
interface flash_boot_if;
    logic        start;
    logic        spi_load;
    logic [15:0] spi_in;
    logic        spi_busy;
    logic [7:0]  spi_rx;
    logic [15:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_we;
    logic        go_load;
    logic        busy;
    logic        done;

    modport master (
        input  start, spi_busy, spi_rx,
        output spi_load, spi_in, sram_addr, sram_data, sram_we, go_load, busy, done
    );

    modport slave (
        output start, spi_busy, spi_rx,
        input  spi_load, spi_in, sram_addr, sram_data, sram_we, go_load, busy, done
    );
endinterface

// File: rtl/flash_boot_ctrl.sv
// Copies WORDS big-endian 16-bit words from SPI flash (READ 0x03) into SRAM, then strobes GO.
// Every output is a register; each SPI byte runs issue -> load -> guard -> wait-for-idle.
module flash_boot_ctrl #(
    parameter logic [23:0] FLASH_ADDR = 24'h010000,
    parameter logic [15:0] WORDS      = 16'd4096,
    parameter logic [15:0] SRAM_BASE  = 16'h0000
) (
    input  logic         clk,
    input  logic         reset,
    flash_boot_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_RD_HI, S_RD_LO, S_WR, S_DESEL, S_GO, S_DONE
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_LOAD, PH_GUARD, PH_WAIT} phase_t;

    localparam logic [15:0] DESEL_CMD = 16'h0100;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        spi_load_q, spi_load_d;
    logic [15:0] spi_in_q, spi_in_d;
    logic [15:0] sram_addr_q, sram_addr_d;
    logic [15:0] sram_data_q, sram_data_d;
    logic        sram_we_q, sram_we_d;
    logic        go_load_q, go_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;

    function automatic logic [15:0] send_word(input state_t s);
        case (s)
            S_CMD:   send_word = 16'h0003;
            S_A2:    send_word = {8'h00, FLASH_ADDR[23:16]};
            S_A1:    send_word = {8'h00, FLASH_ADDR[15:8]};
            S_A0:    send_word = {8'h00, FLASH_ADDR[7:0]};
            S_DESEL: send_word = DESEL_CMD;
            default: send_word = 16'h0000;
        endcase
    endfunction

    function automatic state_t after_send(input state_t s);
        case (s)
            S_CMD:   after_send = S_A2;
            S_A2:    after_send = S_A1;
            S_A1:    after_send = S_A0;
            S_A0:    after_send = S_RD_HI;
            S_RD_HI: after_send = S_RD_LO;
            S_RD_LO: after_send = S_WR;
            S_DESEL: after_send = S_GO;
            default: after_send = S_IDLE;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            spi_load_q  <= 1'b0;
            spi_in_q    <= DESEL_CMD;
            sram_addr_q <= SRAM_BASE;
            sram_data_q <= 16'h0000;
            sram_we_q   <= 1'b0;
            go_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            spi_load_q  <= spi_load_d;
            spi_in_q    <= spi_in_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            sram_we_q   <= sram_we_d;
            go_load_q   <= go_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        spi_load_d  = 1'b0;
        spi_in_d    = spi_in_q;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        sram_we_d   = 1'b0;
        go_load_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 16'd1;

        // Advance the address only after the write strobe has been presented with the old one.
        if (sram_we_q && state_q == S_RD_HI) begin
            sram_addr_d = sram_addr_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    cnt_d       = 16'h0000;
                    sram_addr_d = SRAM_BASE;
                    phase_d     = PH_ISSUE;
                    state_d     = (WORDS == 16'd0) ? S_DESEL : S_CMD;
                end
            end
            S_WR: begin
                sram_we_d = 1'b1;
                cnt_d     = cnt_inc;
                phase_d   = PH_ISSUE;
                state_d   = (cnt_inc == WORDS) ? S_DESEL : S_RD_HI;
            end
            S_GO: begin
                go_load_d = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: begin
                        spi_load_d = 1'b1;
                        spi_in_d   = send_word(state_q);
                        phase_d    = PH_LOAD;
                    end
                    PH_LOAD:  phase_d = PH_GUARD;
                    PH_GUARD: phase_d = PH_WAIT;
                    default: begin
                        if (!bus.spi_busy) begin
                            if (state_q == S_RD_HI) sram_data_d[15:8] = bus.spi_rx;
                            if (state_q == S_RD_LO) sram_data_d[7:0]  = bus.spi_rx;
                            state_d = after_send(state_q);
                            phase_d = PH_ISSUE;
                        end
                    end
                endcase
            end
        endcase
    end

    assign bus.spi_load  = spi_load_q;
    assign bus.spi_in    = spi_in_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_data = sram_data_q;
    assign bus.sram_we   = sram_we_q;
    assign bus.go_load   = go_load_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_flash_boot_ctrl.sv
// Bench for flash_boot_ctrl: three configurations (2 words, 0 words, 2 words at SRAM_BASE=FFFF),
// each with a behavioural SPI flash engine and a log of SPI commands, SRAM writes and GO strobes.
module tb_flash_boot_ctrl;
    localparam logic [15:0] P_WORDS [3] = '{16'd2, 16'd0, 16'd2};
    localparam logic [15:0] P_BASE  [3] = '{16'h0000, 16'h0000, 16'hFFFF};
    localparam logic [7:0]  RDATA   [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};

    logic       clk;
    logic       rst;
    logic       log_clr;
    logic [2:0] start_r;
    logic [2:0] done_w;
    logic [2:0] busy_w;
    int         hold_cyc [3];

    int nchecks;
    int nerr;

    flash_boot_if bus [3] ();

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : m
        int          cnt;
        logic        sbusy;
        logic [7:0]  rx;
        int          idx;
        logic [15:0] sent [$];
        logic [15:0] wa [$];
        logic [15:0] wd [$];
        int          ngo;
        int          nviol;

        flash_boot_ctrl #(
            .FLASH_ADDR(24'h010000),
            .WORDS     (P_WORDS[g]),
            .SRAM_BASE (P_BASE[g])
        ) dut (
            .clk  (clk),
            .reset(rst),
            .bus  (bus[g])
        );

        assign bus[g].start    = start_r[g];
        assign bus[g].spi_busy = sbusy;
        assign bus[g].spi_rx   = rx;
        assign done_w[g]       = bus[g].done;
        assign busy_w[g]       = bus[g].busy;

        // Flash engine: busy for hold_cyc cycles after each load; data bytes follow cmd+3 addr bytes.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                sbusy <= 1'b0;
                cnt   <= 0;
                rx    <= 8'h00;
                idx   <= 0;
            end else if (bus[g].spi_load) begin
                sbusy <= 1'b1;
                cnt   <= hold_cyc[g];
                if (bus[g].spi_in[8]) begin
                    idx <= 0;
                end else begin
                    idx <= idx + 1;
                    rx  <= (idx >= 4) ? RDATA[(idx - 4) % 4] : 8'hFF;
                end
            end else if (sbusy) begin
                if (cnt <= 1) sbusy <= 1'b0;
                cnt <= cnt - 1;
            end
        end

        always @(posedge clk) begin
            if (log_clr) begin
                sent.delete();
                wa.delete();
                wd.delete();
                ngo   <= 0;
                nviol <= 0;
            end else begin
                if (bus[g].spi_load) begin
                    sent.push_back(bus[g].spi_in);
                    if (sbusy) nviol <= nviol + 1;
                end
                if (bus[g].sram_we) begin
                    wa.push_back(bus[g].sram_addr);
                    wd.push_back(bus[g].sram_data);
                end
                if (bus[g].go_load) ngo <= ngo + 1;
            end
        end
    end

    typedef struct {
        string       name;
        int          g;
        int          hold;
        bit          spam;
        int          nsent;
        logic [15:0] sent [9];
        int          nwr;
        logic [15:0] wa [2];
        logic [15:0] wd [2];
    } vec_t;

    vec_t        vt [5];
    logic [15:0] cs [$];
    logic [15:0] cwa [$];
    logic [15:0] cwd [$];
    int          cgo;
    int          cviol;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fetch(input int g);
        case (g)
            0:       begin cs = m[0].sent; cwa = m[0].wa; cwd = m[0].wd; cgo = m[0].ngo; cviol = m[0].nviol; end
            1:       begin cs = m[1].sent; cwa = m[1].wa; cwd = m[1].wd; cgo = m[1].ngo; cviol = m[1].nviol; end
            default: begin cs = m[2].sent; cwa = m[2].wa; cwd = m[2].wd; cgo = m[2].ngo; cviol = m[2].nviol; end
        endcase
    endtask

    task automatic clear_logs();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        hold_cyc[v.g] = v.hold;
        clear_logs();
        start_r[v.g] = 1'b1;
        @(negedge clk);
        start_r[v.g] = 1'b0;
        chk({v.name, " busy after start"}, 32'(busy_w[v.g]), 32'd1);
        chk({v.name, " done cleared"}, 32'(done_w[v.g]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_w[v.g]) begin
                seen = 1'b1;
                break;
            end
            start_r[v.g] = v.spam && (i % 5 == 2);
            @(negedge clk);
        end
        start_r[v.g] = 1'b0;
        chk({v.name, " done reached"}, 32'(seen), 32'd1);
        chk({v.name, " busy low at done"}, 32'(busy_w[v.g]), 32'd0);
        repeat (30) @(negedge clk);
        fetch(v.g);
        chk({v.name, " spi byte count"}, 32'(cs.size()), 32'(v.nsent));
        for (int i = 0; i < v.nsent; i++) begin
            if (i < cs.size()) chk($sformatf("%s spi_in[%0d]", v.name, i), 32'(cs[i]), 32'(v.sent[i]));
        end
        chk({v.name, " write count"}, 32'(cwa.size()), 32'(v.nwr));
        for (int i = 0; i < v.nwr; i++) begin
            if (i < cwa.size()) begin
                chk($sformatf("%s sram_addr[%0d]", v.name, i), 32'(cwa[i]), 32'(v.wa[i]));
                chk($sformatf("%s sram_data[%0d]", v.name, i), 32'(cwd[i]), 32'(v.wd[i]));
            end
        end
        chk({v.name, " go pulses"}, 32'(cgo), 32'd1);
        chk({v.name, " load during busy"}, 32'(cviol), 32'd0);
        chk({v.name, " done sticky"}, 32'(done_w[v.g]), 32'd1);
        chk({v.name, " idle after"}, 32'(busy_w[v.g]), 32'd0);
    endtask

    initial begin
        logic [15:0] seq2 [9];
        logic [15:0] seq0 [9];
        bit          hit;
        seq2 = '{16'h0003, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0100};
        seq0 = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vt[0] = '{"w2_hold1",  0, 1,  1'b0, 9, seq2, 2, '{16'h0000, 16'h0001}, '{16'h1234, 16'hABCD}};
        vt[1] = '{"w2_hold20", 0, 20, 1'b0, 9, seq2, 2, '{16'h0000, 16'h0001}, '{16'h1234, 16'hABCD}};
        vt[2] = '{"w0",        1, 1,  1'b0, 1, seq0, 0, '{16'h0000, 16'h0000}, '{16'h0000, 16'h0000}};
        vt[3] = '{"wrap",      2, 3,  1'b0, 9, seq2, 2, '{16'hFFFF, 16'h0000}, '{16'h1234, 16'hABCD}};
        vt[4] = '{"spam",      0, 4,  1'b1, 9, seq2, 2, '{16'h0000, 16'h0001}, '{16'h1234, 16'hABCD}};

        nchecks     = 0;
        nerr        = 0;
        start_r     = 3'b000;
        hold_cyc    = '{1, 1, 1};
        log_clr     = 1'b1;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        // Reset values
        chk("rst spi_load",  32'(bus[0].spi_load),  32'd0);
        chk("rst spi_in",    32'(bus[0].spi_in),    32'h0100);
        chk("rst sram_addr", 32'(bus[0].sram_addr), 32'h0000);
        chk("rst sram_addr base FFFF", 32'(bus[2].sram_addr), 32'hFFFF);
        chk("rst sram_data", 32'(bus[0].sram_data), 32'h0000);
        chk("rst sram_we",   32'(bus[0].sram_we),   32'd0);
        chk("rst go_load",   32'(bus[0].go_load),   32'd0);
        chk("rst busy",      32'(bus[0].busy),      32'd0);
        chk("rst done",      32'(bus[0].done),      32'd0);
        rst     = 1'b0;
        log_clr = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(vt[k]);

        // Abort with reset while the second word's low byte is in flight
        hold_cyc[0] = 5;
        clear_logs();
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m[0].sent.size() == 8) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort reached RD_LO word 1", 32'(hit), 32'd1);
        chk("abort one write before reset", 32'(m[0].wa.size()), 32'd1);
        chk("abort busy before reset", 32'(bus[0].busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort spi_load",  32'(bus[0].spi_load),  32'd0);
        chk("abort spi_in",    32'(bus[0].spi_in),    32'h0100);
        chk("abort sram_addr", 32'(bus[0].sram_addr), 32'h0000);
        chk("abort sram_data", 32'(bus[0].sram_data), 32'h0000);
        chk("abort sram_we",   32'(bus[0].sram_we),   32'd0);
        chk("abort go_load",   32'(bus[0].go_load),   32'd0);
        chk("abort busy",      32'(bus[0].busy),      32'd0);
        chk("abort done",      32'(bus[0].done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        fetch(0);
        chk("abort no later write", 32'(cwa.size()), 32'd1);
        chk("abort no go", 32'(cgo), 32'd0);
        chk("abort stays idle", 32'(busy_w[0]), 32'd0);

        run_vec(vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
